msrv32_pc_gen_block: RTL

Parametrised program-counter generator, successor to the single-register PC stage at the front of the msrv32 pipeline. It holds the fetch PC, sequences a post-reset boot delay, advances on an accepted fetch handshake, applies stall and redirect (branch/jump/trap) requests with fixed priority, and diverts misaligned redirect targets to a trap vector. It feeds the instruction-fetch stage and reports PC+4 for link-address generation.

---
 rtl/msrv32_pc_gen_block.sv | 124 ++++++++++++
 1 files changed

// File: rtl/msrv32_pc_gen_block.sv
// Program-counter generator: boot delay, sequential advance, redirects, misaligned-target trap.
// Latency: redirect target visible on pc_out one cycle after the redirect edge; pc_plus_4_out is combinational.
// Backpressure: pc_out holds while fetch_valid_out=1 and fetch_ready_in=0 or stall_in=1; a redirect may replace it.
// Optional feature: define MSRV32_PC_RVC_EN for 16-bit instruction steps and halfword-aligned redirect targets.
module msrv32_pc_gen_block #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              BOOT_CYCLES  = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            stall_in,
    input  logic            redirect_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    input  logic            fetch_ready_in,
`ifdef MSRV32_PC_RVC_EN
    input  logic            fetch_len2_in,
`endif
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus_4_out,
    output logic            fetch_valid_out,
    output logic            misaligned_out,
    output logic [XLEN-1:0] misaligned_addr_out,
    output logic [31:0]     fetch_count_out
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_boot_cnt;
    logic [XLEN-1:0] r_pc;
    logic            r_fetch_valid;
    logic            r_misaligned;
    logic [XLEN-1:0] r_mis_addr;
    logic [31:0]     r_fetch_count;

    logic            w_accept;
    logic            w_target_misaligned;
    logic [XLEN-1:0] w_step;

    // Decode the fetch handshake, redirect alignment and sequential step size.
    always_comb begin
        w_accept = r_fetch_valid & fetch_ready_in & ~stall_in;
`ifdef MSRV32_PC_RVC_EN
        w_target_misaligned = redirect_pc_in[0];
        w_step              = fetch_len2_in ? XLEN'(2) : XLEN'(4);
`else
        w_target_misaligned = |redirect_pc_in[1:0];
        w_step              = XLEN'(4);
`endif
    end

    // Boot/run/trap sequencing with PC update priority: redirect, stall, accepted fetch.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state       <= ST_BOOT;
            r_boot_cnt    <= 4'd0;
            r_pc          <= RESET_VECTOR;
            r_fetch_valid <= 1'b0;
            r_misaligned  <= 1'b0;
            r_mis_addr    <= '0;
            r_fetch_count <= 32'd0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    // Redirects and stalls are ignored until the first fetch is offered.
                    if (r_boot_cnt == 4'(BOOT_CYCLES - 1)) begin
                        r_state       <= ST_RUN;
                        r_fetch_valid <= 1'b1;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    // A fetch accepted alongside a redirect is still counted.
                    if (w_accept) begin
                        r_fetch_count <= r_fetch_count + 32'd1;
                    end
                    if (redirect_in && !w_target_misaligned) begin
                        r_pc <= redirect_pc_in;
                    end else if (redirect_in) begin
                        r_pc          <= TRAP_VECTOR;
                        r_mis_addr    <= redirect_pc_in;
                        r_misaligned  <= 1'b1;
                        r_fetch_valid <= 1'b0;
                        r_state       <= ST_TRAP;
                    end else if (stall_in) begin
                        r_pc <= r_pc;
                    end else if (w_accept) begin
                        r_pc <= r_pc + w_step;
                    end
                end
                ST_TRAP: begin
                    // Single cycle with fetch withheld; the trap vector is then offered.
                    r_misaligned  <= 1'b0;
                    r_fetch_valid <= 1'b1;
                    r_state       <= ST_RUN;
                end
                default: begin
                    r_state       <= ST_BOOT;
                    r_boot_cnt    <= 4'd0;
                    r_fetch_valid <= 1'b0;
                    r_misaligned  <= 1'b0;
                end
            endcase
        end
    end

    // Drive outputs from registered state; link address is combinational.
    always_comb begin
        pc_out              = r_pc;
        pc_plus_4_out       = r_pc + XLEN'(4);
        fetch_valid_out     = r_fetch_valid;
        misaligned_out      = r_misaligned;
        misaligned_addr_out = r_mis_addr;
        fetch_count_out     = r_fetch_count;
    end

endmodule
